// File: rtl/feed_pkg.sv
// Shared types and constants for the feed dispenser.
// Contents: FSM state encoding, the manual-request slot code, a packed
// time-of-day record, and constant functions that turn the parameters
// (clock rate, microseconds, milliseconds) into cycle counts.
package feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } feed_state_e;

  localparam int          NUM_SLOTS   = 3;
  localparam logic [1:0]  MANUAL_SLOT = 2'd3;

  // One time-of-day value, compared as a whole (8-bit fields, no BCD).
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic       pm;
  } tod_t;

  function automatic int unsigned frame_cycles(input int unsigned clk_hz,
                                               input int unsigned pwm_hz);
    return clk_hz / pwm_hz;
  endfunction

  // 64-bit intermediate: us * clk_hz overflows 32 bits at real clock rates.
  function automatic int unsigned us_cycles(input int unsigned clk_hz,
                                            input int unsigned us);
    return 32'((64'(us) * 64'(clk_hz)) / 64'd1000000);
  endfunction

  function automatic int unsigned ms_cycles(input int unsigned clk_hz,
                                            input int unsigned ms);
    return 32'((64'(ms) * 64'(clk_hz)) / 64'd1000);
  endfunction

  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// 50 Hz-style servo PWM generator.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-low reset
//   open_req  in   1 = drive open pulse width, 0 = closed width
//   motor_pwm out  registered PWM output
// The pulse width is only sampled at the start of a frame, so a change of
// open_req mid-frame never produces a shortened or stretched pulse.
module servo_pwm_gen
  import feed_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned PWM_HZ          = 50,
  parameter int unsigned PULSE_CLOSED_US = 1000,
  parameter int unsigned PULSE_OPEN_US   = 2000
) (
  input  logic clock,
  input  logic reset,
  input  logic open_req,
  output logic motor_pwm
);

  localparam int unsigned FRAME = frame_cycles(CLK_HZ, PWM_HZ);
  localparam int          WW    = $clog2(FRAME + 1);

  localparam logic [WW-1:0] FRAME_LAST = WW'(FRAME - 1);
  localparam logic [WW-1:0] WID_CLOSED = WW'(us_cycles(CLK_HZ, PULSE_CLOSED_US));
  localparam logic [WW-1:0] WID_OPEN   = WW'(us_cycles(CLK_HZ, PULSE_OPEN_US));

  logic [WW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] width_q, width_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    cnt_d   = (cnt_q == FRAME_LAST) ? '0 : cnt_q + 1'b1;
    width_d = width_q;
    // Frame boundary: pick up the new width for the whole coming frame.
    if (cnt_q == '0) width_d = open_req ? WID_OPEN : WID_CLOSED;
    pwm_d   = (cnt_q < width_d);
  end

  // Output is registered: low during the reset cycle, then the pulse
  // restarts from frame position 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      width_q <= WID_CLOSED;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign motor_pwm = pwm_q;

endmodule

// File: rtl/feed_dispense_ctrl.sv
// Feed scheduler and servo driver.
// Compares the current time against three schedule slots (plus a manual
// request), opens the feeder servo for `duration` seconds (clamped to
// 1..DUR_MAX), holds it closed for CLOSE_HOLD_MS, then returns to idle.
// Ports:
//   clock, reset              system clock, synchronous active-low reset
//   cur_hour/min/ampm         current time of day
//   slot_hour/min/ampm/en     three packed schedule slots {s2,s1,s0}
//   duration                  open time in seconds
//   manual_feed               one-cycle feed request
//   motor_pwm                 servo PWM
//   feeding                   high while OPEN or CLOSE
//   fired                     per-slot "already fired this minute"
//   last_slot                 index of the last feed source, 3 = manual
//   feed_count                (FEED_COUNT_EN only) saturating feed counter
// Build option: define FEED_COUNT_EN to add the feed_count output.
module feed_dispense_ctrl
  import feed_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned PWM_HZ          = 50,
  parameter int unsigned PULSE_CLOSED_US = 1000,
  parameter int unsigned PULSE_OPEN_US   = 2000,
  parameter int unsigned CLOSE_HOLD_MS   = 500,
  parameter int unsigned DUR_MAX         = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_min,
  input  logic        cur_ampm,
  input  logic [23:0] slot_hour,
  input  logic [23:0] slot_min,
  input  logic [2:0]  slot_ampm,
  input  logic [2:0]  slot_en,
  input  logic [31:0] duration,
  input  logic        manual_feed,
  output logic        motor_pwm,
  output logic        feeding,
  output logic [2:0]  fired,
  output logic [1:0]  last_slot
`ifdef FEED_COUNT_EN
  ,
  output logic [15:0] feed_count
`endif
);

  localparam int unsigned SEC_CYC  = CLK_HZ;
  localparam int unsigned HOLD_CYC = ms_cycles(CLK_HZ, CLOSE_HOLD_MS);
  localparam int          TW       = $clog2(max_u(SEC_CYC, HOLD_CYC) + 1);
  localparam int          DW       = $clog2(DUR_MAX + 1);

  localparam logic [TW-1:0] SEC_LAST  = TW'(SEC_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);

  feed_state_e state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [DW-1:0]        sec_q, sec_d;
  logic [DW-1:0]        dur_q, dur_d, dur_clamp;
  logic [1:0]           last_q, last_d;
  logic [NUM_SLOTS-1:0] match_c, match_q, fired_q, pend;
  logic [1:0]           win;

  // Slot matching
  tod_t cur_t;
  assign cur_t = '{hour: cur_hour, minute: cur_min, pm: cur_ampm};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    tod_t slot_t;
    assign slot_t     = '{hour: slot_hour[8*i +: 8], minute: slot_min[8*i +: 8],
                          pm: slot_ampm[i]};
    assign match_c[i] = slot_en[i] && (slot_t == cur_t);
  end

  assign pend = match_q & ~fired_q;

  always_comb begin
    win = 2'd2;
    if (pend[1]) win = 2'd1;
    if (pend[0]) win = 2'd0;
  end

  always_comb begin
    if (duration == 32'd0)        dur_clamp = DW'(1);
    else if (duration > DUR_MAX)  dur_clamp = DW'(DUR_MAX);
    else                          dur_clamp = duration[DW-1:0];
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    sec_d   = sec_q;
    dur_d   = dur_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        sec_d  = '0;
        if (|pend) begin
          state_d = ST_OPEN;
          last_d  = win;
          dur_d   = dur_clamp;
        end else if (manual_feed) begin
          state_d = ST_OPEN;
          last_d  = MANUAL_SLOT;
          dur_d   = dur_clamp;
        end
      end
      ST_OPEN: begin
        if (tick_q == SEC_LAST) begin
          tick_d = '0;
          if (sec_q == dur_q - 1'b1) begin
            state_d = ST_CLOSE;
            sec_d   = '0;
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_CLOSE: begin
        if (tick_q == HOLD_LAST) begin
          tick_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // fired simply follows the registered match one cycle later: in IDLE the
  // trigger and all co-matching slots set together, during a feed a new
  // match is marked and dropped, and the bit falls once the slot stops
  // matching.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      sec_q   <= '0;
      dur_q   <= DW'(1);
      last_q  <= 2'd0;
      match_q <= '0;
      fired_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
      match_q <= match_c;
      fired_q <= match_q;
    end
  end

`ifdef FEED_COUNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clock) begin
    if (!reset)
      cnt_q <= '0;
    else if (state_q == ST_IDLE && state_d == ST_OPEN && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end
  assign feed_count = cnt_q;
`endif

  servo_pwm_gen #(
    .CLK_HZ          (CLK_HZ),
    .PWM_HZ          (PWM_HZ),
    .PULSE_CLOSED_US (PULSE_CLOSED_US),
    .PULSE_OPEN_US   (PULSE_OPEN_US)
  ) u_pwm (
    .clock     (clock),
    .reset     (reset),
    .open_req  (state_q == ST_OPEN),
    .motor_pwm (motor_pwm)
  );

  assign feeding   = (state_q != ST_IDLE);
  assign fired     = fired_q;
  assign last_slot = last_q;

endmodule

// File: tb/tb_feed_dispense_ctrl.sv
// Scoreboard bench for feed_dispense_ctrl. Scaled clock (CLK_HZ=4000,
// DUR_MAX=3) keeps every scenario short: frame=80, closed=4, open=8,
// 1 s=4000 cycles, hold=2000 cycles.
module tb_feed_dispense_ctrl;

  localparam int SEC  = 4000;
  localparam int HOLD = 2000;
  localparam int CW   = 4;
  localparam int OW   = 8;
  localparam int DMAX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cur_hour, cur_min;
  logic        cur_ampm;
  logic [23:0] slot_hour, slot_min;
  logic [2:0]  slot_ampm, slot_en;
  logic [31:0] duration;
  logic        manual_feed;
  logic        motor_pwm, feeding;
  logic [2:0]  fired;
  logic [1:0]  last_slot;
`ifdef FEED_COUNT_EN
  logic [15:0] feed_count;
`endif

  feed_dispense_ctrl #(
    .CLK_HZ(4000), .PWM_HZ(50), .PULSE_CLOSED_US(1000), .PULSE_OPEN_US(2000),
    .CLOSE_HOLD_MS(500), .DUR_MAX(DMAX)
  ) dut (
    .clock(clock), .reset(reset),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_ampm(cur_ampm),
    .slot_hour(slot_hour), .slot_min(slot_min), .slot_ampm(slot_ampm),
    .slot_en(slot_en), .duration(duration), .manual_feed(manual_feed),
    .motor_pwm(motor_pwm), .feeding(feeding), .fired(fired),
    .last_slot(last_slot)
`ifdef FEED_COUNT_EN
    , .feed_count(feed_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] slot;
    logic [2:0] fired;
    int         len;
    int         lat;
    int         pmax;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, cyc = 0, chg_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [2:0] f, input int len,
                      input int lat);
    exp_t e;
    e.slot = s; e.fired = f; e.len = len; e.lat = lat; e.pmax = OW;
    q.push_back(e);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic pm);
    cur_hour = h; cur_min = m; cur_ampm = pm; chg_cyc = cyc;
  endtask

  task automatic pulse_manual();
    manual_feed = 1'b1; chg_cyc = cyc;
    @(negedge clock);
    manual_feed = 1'b0;
  endtask

  task automatic wait_feed(input logic v, input int budget, input string nm);
    int n = 0;
    while (feeding !== v && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, feeding, v);
  endtask

  task automatic check_closed_pulse(input string nm);
    int n = 0;
    @(negedge clock);
    chk({nm, "_start"}, motor_pwm, 1);
    while (motor_pwm && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_width"}, n, CW);
  endtask

  // Monitor: pops an expectation on each feed start, checks it at start/end.
  exp_t cur_e;
  bit   have = 0, prev = 0;
  int   run = 0, len = 0, pmax = 0;

  initial begin
    forever begin
      @(negedge clock);
      run = motor_pwm ? run + 1 : 0;
      if (feeding && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_feed", 1, 0);
          have = 0;
        end else begin
          cur_e = q.pop_front();
          have  = 1;
          chk("last_slot", last_slot, cur_e.slot);
          chk("fired_at_start", fired, cur_e.fired);
          chk("latency", cyc - chg_cyc, cur_e.lat);
        end
        len = 0; pmax = 0;
      end
      if (feeding) begin
        len++;
        if (run > pmax) pmax = run;
      end
      if (!feeding && prev && have) begin
        chk("feed_len", len, cur_e.len);
        chk("pwm_high_max", pmax, cur_e.pmax);
        have = 0;
      end
      prev = feeding;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_hour = 8'd7; cur_min = 8'd29; cur_ampm = 1'b0;
    slot_hour = {8'd12, 8'd12, 8'd7};
    slot_min  = {8'd0, 8'd0, 8'd30};
    slot_ampm = 3'b110;
    slot_en   = 3'b001;
    duration  = 32'd2;
    manual_feed = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pwm", motor_pwm, 0);
    chk("rst_feeding", feeding, 0);
    chk("rst_fired", fired, 0);
    chk("rst_last_slot", last_slot, 0);
`ifdef FEED_COUNT_EN
    chk("rst_count", feed_count, 0);
`endif
    reset = 1'b1;
    check_closed_pulse("idle_pulse");

    // Slot 0 at 7:30 AM, duration 2
    repeat (5) @(negedge clock);
    push(2'd0, 3'b001, 2*SEC + HOLD, 2);
    set_time(8'd7, 8'd30, 1'b0);
    wait_feed(1'b1, 10, "s1_rise");
    wait_feed(1'b0, 3*SEC + HOLD, "s1_done");
    repeat (200) @(negedge clock);   // same minute: must not refire
    chk("s1_fired_hold", fired, 3'b001);
    set_time(8'd7, 8'd31, 1'b0);
    repeat (3) @(negedge clock);
    chk("s1_fired_clear", fired, 3'b000);

    // Slots 1 and 2 both at 12:00 PM
    slot_en  = 3'b111;
    duration = 32'd1;
    push(2'd1, 3'b110, SEC + HOLD, 2);
    set_time(8'd12, 8'd0, 1'b1);
    wait_feed(1'b1, 10, "s2_rise");
    wait_feed(1'b0, 2*SEC + HOLD, "s2_done");
    repeat (20) @(negedge clock);
    chk("s2_last_slot", last_slot, 1);
    set_time(8'd12, 8'd1, 1'b1);
    repeat (3) @(negedge clock);
    chk("s2_fired_clear", fired, 3'b000);

    // Manual feed, duration 0 -> 1 s; second pulse during OPEN ignored
    duration = 32'd0;
    push(2'd3, 3'b000, SEC + HOLD, 1);
    pulse_manual();
    wait_feed(1'b1, 10, "s3_rise");
    repeat (500) @(negedge clock);
    pulse_manual();
    wait_feed(1'b0, 2*SEC + HOLD, "s3_done");
    repeat (50) @(negedge clock);

    // Clamp: duration 1000 -> DUR_MAX; slot 0 matching mid-feed is dropped
    duration = 32'd1000;
    push(2'd3, 3'b000, DMAX*SEC + HOLD, 1);
    pulse_manual();
    wait_feed(1'b1, 10, "s4_rise");
    repeat (1000) @(negedge clock);
    set_time(8'd7, 8'd30, 1'b0);
    repeat (3) @(negedge clock);
    chk("s4_fired_midfeed", fired, 3'b001);
    wait_feed(1'b0, (DMAX+1)*SEC + HOLD, "s4_done");
    repeat (200) @(negedge clock);
    chk("s4_fired_after", fired, 3'b001);
    set_time(8'd7, 8'd32, 1'b0);
    repeat (3) @(negedge clock);
    chk("s4_fired_clear", fired, 3'b000);
`ifdef FEED_COUNT_EN
    chk("count_4", feed_count, 4);
`endif

    // Reset mid-OPEN during a slot 1/2 feed
    duration = 32'd2;
    push(2'd1, 3'b110, 301, 2);
    set_time(8'd12, 8'd0, 1'b1);
    wait_feed(1'b1, 10, "s5_rise");
    repeat (300) @(negedge clock);
    reset = 1'b0;
    cur_min = 8'd33;
    @(negedge clock);
    chk("s5_feeding", feeding, 0);
    chk("s5_fired", fired, 3'b000);
    chk("s5_last_slot", last_slot, 0);
    chk("s5_pwm", motor_pwm, 0);
`ifdef FEED_COUNT_EN
    chk("s5_count", feed_count, 0);
`endif
    reset = 1'b1;
    check_closed_pulse("s5_pulse");

    // Normal feed after reset
    repeat (20) @(negedge clock);
    duration = 32'd1;
    push(2'd3, 3'b000, SEC + HOLD, 1);
    pulse_manual();
    wait_feed(1'b1, 10, "s6_rise");
    wait_feed(1'b0, 2*SEC + HOLD, "s6_done");
    repeat (20) @(negedge clock);
`ifdef FEED_COUNT_EN
    chk("s6_count", feed_count, 1);
`endif
    chk("pending_expect", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feed_dispense_ctrl.md
Name: feed_dispense_ctrl

Overview:
- Hardware feed scheduler and servo driver between the register file's schedule/time outputs and the motor pin; replaces the raw pwmControl[0] drive of motorPWM.
- Compares the current time against three schedule slots, plus a manual request.
- On a trigger, drives a 50 Hz servo PWM to the open position for `duration` seconds, then to the closed position for a fixed hold time.
- Suppresses re-triggering within the same matching minute.

Parameters:
- CLK_HZ, 50000000, clock cycles per second
- PWM_HZ, 50, servo frame rate; frame = CLK_HZ/PWM_HZ cycles
- PULSE_CLOSED_US, 1000, high time per frame in closed position
- PULSE_OPEN_US, 2000, high time per frame in open position
- CLOSE_HOLD_MS, 500, time spent in CLOSE before returning to IDLE
- DUR_MAX, 60, maximum open time in seconds (clamp)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cur_hour  in  8  current hour, 1..12
- cur_min  in  8  current minute, 0..59
- cur_ampm  in  1  0=AM, 1=PM
- slot_hour  in  24  {slot2,slot1,slot0} hours, 8 b each
- slot_min  in  24  {slot2,slot1,slot0} minutes, 8 b each
- slot_ampm  in  3  per-slot AM/PM
- slot_en  in  3  per-slot enable
- duration  in  32  open time in seconds
- manual_feed  in  1  one-cycle feed request (debounced)
- motor_pwm  out  1  servo PWM
- feeding  out  1  high in OPEN and CLOSE
- fired  out  3  per-slot "already fired this minute" flags
- last_slot  out  2  slot index of last feed; 3 = manual

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; fired=0, feeding=0, last_slot=0.
  - PWM frame counter=0; pulse width=closed.
  - motor_pwm=0 for that cycle, then resumes the closed pulse from frame start.
  - Reset mid-feed aborts immediately to closed PWM.
- Match for slot i: slot_en[i] && hour/min/ampm all equal current. Combinational, registered once.
- States:
  - IDLE: on a registered match of any unfired slot, go OPEN the next cycle. Lowest index wins; all simultaneously matching slots set their fired bit. last_slot = winning index.
  - IDLE: manual_feed with no match -> OPEN, last_slot=3.
  - Latency: time change at edge N -> feeding=1 at edge N+2.
  - OPEN: seconds counter (CLK_HZ cycles/s) runs for D seconds, D = clamp(duration, 1, DUR_MAX); duration=0 behaves as 1. Then -> CLOSE.
  - CLOSE: counts CLOSE_HOLD_MS ms, then -> IDLE.
- Ignored inputs: manual_feed and new matches are ignored in OPEN and CLOSE. A slot matching during a feed sets its fired bit and is dropped, not queued.
- fired[i] clears when slot i no longer matches (minute rolls over or slot edited). A slot cannot re-fire in the same minute.
- PWM:
  - Frame counter 0..CLK_HZ/PWM_HZ-1, wraps.
  - motor_pwm = (counter < width).
  - Width (open/closed, in cycles = US*CLK_HZ/1e6) latches only at counter==0, so no glitched frames. Open pulses begin at the next frame boundary after entering OPEN.
- Widths: compare 8-bit fields exactly; no BCD handling. Counters are sized with $clog2 from parameters.

Optional Feature:
- FEED_COUNT_EN
  - Defined: adds output feed_count[15:0]. Increments by 1 on each IDLE->OPEN transition, saturates at 16'hFFFF, and clears only on reset.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- feed_pkg:
  - State encoding IDLE=0, OPEN=1, CLOSE=2.
  - MANUAL_SLOT=2'd3.
  - Derived cycle-count constant functions (frame, pulse widths, ms/s ticks).
- Sub-module servo_pwm_gen (clock, reset, open_req -> motor_pwm):
  - Owns the frame counter and boundary-latched width.
  - The parent owns the FSM, slot matching and fired flags.

Test Plan:
- Test parameters for all scenarios: CLK_HZ=100000, so frame=2000 cycles, closed=100, open=200, 1 s=100000 cycles, hold=50000 cycles.
- Slot0 enabled at 7:30 AM, duration=2. Drive cur time 7:29 AM, then 7:30 AM. Expect:
  - feeding rises 2 cycles after the change;
  - first open frame has 200-cycle highs;
  - OPEN lasts 200000 cycles, CLOSE 50000 cycles;
  - last_slot=0, fired=001.
- Hold the time at 7:30 AM after the feed completes -> no second feed. Advance to 7:31 -> fired[0] clears.
- Slots 1 and 2 both at 12:00 PM, enabled -> a single feed with last_slot=1 and fired=110.
- manual_feed pulse in IDLE with duration=0 -> OPEN lasts exactly 100000 cycles, last_slot=3. A second pulse during OPEN is ignored.
- duration=1000 -> OPEN clamped to 60 s (6000000 cycles).
- Assert reset=0 mid-OPEN -> next cycle feeding=0, fired=0, and closed pulses resume from frame start.
- With FEED_COUNT_EN: three feeds produce feed_count=3.
